// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Parametrised universal shift register used as the serialiser/deserialiser
// stage between bit-serial links and word-wide logic. Supports hold, shift
// right, shift left and parallel load. A shift counter tracks progress through
// the current WIDTH-bit frame and produces a registered one-cycle frame_done
// pulse when a frame completes.
//
// Parameters:
//   WIDTH  register length in bits (2..64)
//   CNT_W  shift counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk         rising-edge clock
//   clear_n     asynchronous active-low reset (q, shift_cnt, frame_done -> 0)
//   mode        00 hold, 01 shift right, 10 shift left, 11 parallel load
//   s_in_r      serial input entering q[WIDTH-1] on a right shift
//   s_in_l      serial input entering q[0] on a left shift
//   p_in        parallel load word
//   s_out_r     q[0]        (right-shift serial output)
//   s_out_l     q[WIDTH-1]  (left-shift serial output)
//   q           register contents
//   shift_cnt   shifts since last load, reset or frame wrap (0..WIDTH-1)
//   frame_done  one-cycle pulse after the WIDTH-th shift of a frame
// -----------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Counter value at which the next shift completes a frame.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             is_shift;

  assign is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

  // Per-bit next-state mux. Each bit picks its upper neighbour on a right
  // shift and its lower neighbour on a left shift; the end bits take the
  // serial inputs instead.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_upper;
      logic from_lower;

      if (gi == WIDTH - 1) begin : g_top
        assign from_upper = s_in_r;
      end else begin : g_not_top
        assign from_upper = q_reg[gi+1];
      end

      if (gi == 0) begin : g_bottom
        assign from_lower = s_in_l;
      end else begin : g_not_bottom
        assign from_lower = q_reg[gi-1];
      end

      assign q_next[gi] = (mode == MODE_SHR)  ? from_upper :
                          (mode == MODE_SHL)  ? from_lower :
                          (mode == MODE_LOAD) ? p_in[gi]   :
                                                q_reg[gi];
    end
  endgenerate

  // Frame counter: both shift directions count toward the same frame; a load
  // discards the partial frame without signalling completion.
  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (mode == MODE_LOAD) begin
      cnt_next = '0;
    end else if (is_shift) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_reg    <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign q          = q_reg;
  assign shift_cnt  = cnt_reg;
  assign frame_done = done_reg;
  assign s_out_r    = q_reg[0];
  assign s_out_l    = q_reg[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Drives three instances (WIDTH = 4, 8, 2) with shared stimulus and compares
// every output against an arithmetic reference model after each clock edge and
// after each asynchronous reset. Directed sequences cover reset, right/left
// shift, load, mixed direction with hold, and aborted frames; a serial-latency
// and frame-cadence run and a long randomized run follow.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        s_in_r = 1'b0;
  logic        s_in_l = 1'b0;
  logic [63:0] p_all = '0;

  logic       sr4, sl4, done4;
  logic [3:0] q4;
  logic [2:0] cnt4;
  logic       sr8, sl8, done8;
  logic [7:0] q8;
  logic [3:0] cnt8;
  logic       sr2, sl2, done2;
  logic [1:0] q2;
  logic [1:0] cnt2;

  universal_shift_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .clear_n(clear_n), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .p_in(p_all[3:0]), .s_out_r(sr4), .s_out_l(sl4), .q(q4),
    .shift_cnt(cnt4), .frame_done(done4));

  universal_shift_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .clear_n(clear_n), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .p_in(p_all[7:0]), .s_out_r(sr8), .s_out_l(sl8), .q(q8),
    .shift_cnt(cnt8), .frame_done(done8));

  universal_shift_reg #(.WIDTH(2)) u_w2 (
    .clk(clk), .clear_n(clear_n), .mode(mode), .s_in_r(s_in_r), .s_in_l(s_in_l),
    .p_in(p_all[1:0]), .s_out_r(sr2), .s_out_l(sl2), .q(q2),
    .shift_cnt(cnt2), .frame_done(done2));

  always #5 clk = ~clk;

  // Gather DUT outputs into arrays indexed by instance.
  logic [63:0] dut_q   [3];
  logic [63:0] dut_cnt [3];
  logic        dut_done[3];
  logic        dut_sr  [3];
  logic        dut_sl  [3];

  assign dut_q[0] = 64'(q4);     assign dut_cnt[0] = 64'(cnt4);
  assign dut_q[1] = 64'(q8);     assign dut_cnt[1] = 64'(cnt8);
  assign dut_q[2] = 64'(q2);     assign dut_cnt[2] = 64'(cnt2);
  assign dut_done[0] = done4;    assign dut_sr[0] = sr4;  assign dut_sl[0] = sl4;
  assign dut_done[1] = done8;    assign dut_sr[1] = sr8;  assign dut_sl[1] = sl8;
  assign dut_done[2] = done2;    assign dut_sr[2] = sr2;  assign dut_sl[2] = sl2;

  // Reference model: register value as an integer, count as a plain integer.
  int              wid[3] = '{4, 8, 2};
  longint unsigned m_q[3];
  int              m_cnt[3];
  bit              m_done[3];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      longint unsigned mask;
      mask = (64'd1 << wid[k]) - 64'd1;
      m_done[k] = 1'b0;
      case (mode)
        2'b01, 2'b10: begin
          if (mode == 2'b01)
            m_q[k] = (m_q[k] >> 1) | (64'(s_in_r) << (wid[k] - 1));
          else
            m_q[k] = ((m_q[k] << 1) | 64'(s_in_l)) & mask;
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == wid[k]) begin
            m_cnt[k]  = 0;
            m_done[k] = 1'b1;
          end
        end
        2'b11: begin
          m_q[k]   = p_all & mask;
          m_cnt[k] = 0;
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s.w%0d.q", tag, wid[k]), dut_q[k], m_q[k]);
      check_val($sformatf("%s.w%0d.cnt", tag, wid[k]), dut_cnt[k], 64'(m_cnt[k]));
      check_val($sformatf("%s.w%0d.done", tag, wid[k]), 64'(dut_done[k]), 64'(m_done[k]));
      check_val($sformatf("%s.w%0d.s_out_r", tag, wid[k]), 64'(dut_sr[k]), 64'(m_q[k][0]));
      check_val($sformatf("%s.w%0d.s_out_l", tag, wid[k]), 64'(dut_sl[k]),
                64'((m_q[k] >> (wid[k] - 1)) & 64'd1));
    end
  endtask

  // One clock transaction: drive inputs, clock, advance model, compare.
  task automatic step(input string tag, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [63:0] p);
    mode = m; s_in_r = sr; s_in_l = sl; p_all = p;
    @(posedge clk);
    if (clear_n) model_edge();
    #1;
    $display("%s mode=%0d sr=%0d sl=%0d q4=%h q8=%h q2=%h cnt4=%0d done4=%0d",
             tag, m, sr, sl, q4, q8, q2, cnt4, done4);
    check_all(tag);
  endtask

  // Pulse clear_n low between edges and check outputs before any edge.
  task automatic pulse_clear(input string tag);
    #2 clear_n = 1'b0;
    #1 model_reset();
    $display("%s clear_n pulsed", tag);
    check_all(tag);
    #1 clear_n = 1'b1;
  endtask

  logic [3:0] exp_q_t2  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001};
  logic       sin_t2    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] mode_t4   [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
  int         cnt_t4    [5] = '{1, 2, 2, 3, 0};
  bit         hist[3][$];

  initial begin
    model_reset();

    // 1. Reset with random inputs, asynchronous check mid-cycle.
    #3;
    check_all("rst_async");
    step("rst_held", 2'(($urandom % 3) + 1), 1'b1, 1'b1, 64'($urandom));
    step("rst_held", 2'b11, 1'b1, 1'b1, 64'hFFFF_FFFF);
    clear_n = 1'b1;
    step("rst_hold", 2'b00, 1'b1, 1'b1, 64'hFF);

    // 2. Right shift 1,0,0,1 on WIDTH=4.
    check_val("t2.cnt_init", dut_cnt[0], 64'd0);
    for (int i = 0; i < 4; i++) begin
      step("t2", 2'b01, sin_t2[i], 1'b0, 64'd0);
      check_val($sformatf("t2.q4[%0d]", i), dut_q[0], 64'(exp_q_t2[i]));
      check_val($sformatf("t2.cnt4[%0d]", i), dut_cnt[0], 64'((i + 1) % 4));
    end
    check_val("t2.s_out_r", 64'(sr4), 64'd1);
    check_val("t2.done", 64'(done4), 64'd1);
    step("t2.after", 2'b00, 1'b0, 1'b0, 64'd0);
    check_val("t2.done_clear", 64'(done4), 64'd0);

    // 3. Load 1010 then two left shifts with s_in_l=0.
    step("t3.load", 2'b11, 1'b0, 1'b0, 64'hA5_A);
    check_val("t3.q4", dut_q[0], 64'hA);
    check_val("t3.s_out_l", 64'(sl4), 64'd1);
    step("t3.shl", 2'b10, 1'b0, 1'b0, 64'd0);
    check_val("t3.q4_a", dut_q[0], 64'h4);
    step("t3.shl", 2'b10, 1'b0, 1'b0, 64'd0);
    check_val("t3.q4_b", dut_q[0], 64'h8);

    // 4. Mixed direction with a hold in the middle.
    step("t4.load", 2'b11, 1'b0, 1'b0, 64'h3C);
    for (int i = 0; i < 5; i++) begin
      step("t4", mode_t4[i], 1'($urandom), 1'($urandom), 64'd0);
      check_val($sformatf("t4.cnt4[%0d]", i), dut_cnt[0], 64'(cnt_t4[i]));
      check_val($sformatf("t4.done4[%0d]", i), 64'(done4), 64'(i == 4));
    end

    // 5. Aborted frames: load and asynchronous clear after three shifts.
    for (int i = 0; i < 3; i++) step("t5a", 2'b01, 1'b1, 1'b0, 64'd0);
    step("t5a.load", 2'b11, 1'b0, 1'b0, 64'h5A);
    check_val("t5a.done4", 64'(done4), 64'd0);
    for (int i = 0; i < 3; i++) step("t5b", 2'b10, 1'b1, 1'b1, 64'd0);
    pulse_clear("t5b.clr");
    step("t5b.hold", 2'b00, 1'b0, 1'b0, 64'd0);
    check_val("t5b.done4", 64'(done4), 64'd0);

    // 6. Continuous right shift: frame cadence and serial latency.
    step("t6.load", 2'b11, 1'b0, 1'b0, 64'($urandom));
    for (int k = 0; k < 3; k++) hist[k].delete();
    for (int n = 1; n <= 16; n++) begin
      step("t6", 2'b01, 1'($urandom), 1'b0, 64'd0);
      for (int k = 0; k < 3; k++) begin
        hist[k].push_back(s_in_r);
        check_val($sformatf("t6.w%0d.cadence", wid[k]), 64'(dut_done[k]),
                  64'((n % wid[k]) == 0));
        if (hist[k].size() == wid[k]) begin
          check_val($sformatf("t6.w%0d.latency", wid[k]), 64'(dut_sr[k]),
                    64'(hist[k].pop_front()));
        end
      end
    end

    // Randomized run with occasional loads and asynchronous clears.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0] m;
      r = $urandom_range(0, 99);
      m = (r < 10) ? 2'b00 : (r < 50) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
      step("rnd", m, 1'($urandom), 1'($urandom), {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 39) == 0) pulse_clear("rnd.clr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
